// File: rtl/i2c_measure_sched.sv
// i2c_measure_sched: round-robin sharing of one I2C measurement engine among NREQ requesters
module i2c_measure_sched #(
  parameter int NREQ = 4,
  parameter int DW = 16,
  parameter int MEAS_HOLD = 8,
  parameter int TIMEOUT = 2000000,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            resetG,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [DW-1:0]   result,
  output logic [IDW-1:0]  result_id,
  output logic            result_valid,
  output logic            result_err,
  output logic            busy,
  output logic            fault,
  output logic            measure,
  input  logic            done,
  input  logic [DW-1:0]   datao
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] H_END = TW'(MEAS_HOLD - 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;
  state_t state, state_n;
  logic [TW-1:0] t;
  logic [IDW-1:0] grant, last_grant, win, idx;
  logic found, done_q, rise;
  int s;
  assign rise = done & ~done_q;
  // Search upward from the slot after the last grant, wrapping once around
  always_comb begin
    win = '0;
    found = 1'b0;
    s = 0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      s = int'(last_grant) + i;
      s = (s >= NREQ) ? s - NREQ : s;
      idx = IDW'(s);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = found ? START : IDLE;
      START:   state_n = (t == H_END) ? WAIT : START;
      WAIT:    state_n = (rise || t == T_MAX) ? RELEASE : WAIT;
      RELEASE: state_n = (!done || t == T_MAX) ? IDLE : RELEASE;
      default: state_n = IDLE;
    endcase
  end
  // The timer restarts on every state change, so it serves both the strobe length and the watchdogs
  always_ff @(posedge clk) begin
    if (resetG) begin
      state <= IDLE;
      t <= '0;
      grant <= '0;
      last_grant <= IDW'(NREQ - 1);
      done_q <= 1'b0;
      measure <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b0;
      ack <= '0;
      result <= '0;
      result_id <= '0;
      result_valid <= 1'b0;
      result_err <= 1'b0;
    end else begin
      state <= state_n;
      done_q <= done;
      t <= (state_n != state) ? '0 : (t == T_MAX) ? t : t + 1'b1;
      measure <= state_n == START;
      busy <= state_n != IDLE;
      ack <= '0;
      result_valid <= 1'b0;
      if (state == IDLE && found) begin
        grant <= win;
        last_grant <= win;
      end
      if (state == WAIT && state_n == RELEASE) begin
        ack <= NREQ'(1) << grant;
        result_valid <= 1'b1;
        result <= rise ? datao : '0;
        result_err <= !rise;
        result_id <= grant;
      end
      if (state == RELEASE && state_n == IDLE && done) fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_measure_sched.sv
// tb_i2c_measure_sched: randomized engine/requester stimulus against a round-robin reference model
`timescale 1ns/1ps
module tb_i2c_measure_sched;
  localparam int T = 1000, H = 8;
  localparam int NORM = 0, TMO = 1, STUCK = 2;
  logic clk = 1'b0, resetG, done, result_valid, result_err, busy, fault, measure;
  logic [3:0] req, ack;
  logic [15:0] datao, result;
  logic [1:0] result_id;
  int n_chk, n_err, lg;
  logic exp_fault;
  i2c_measure_sched #(.NREQ(4), .DW(16), .MEAS_HOLD(H), .TIMEOUT(T)) dut (
    .clk(clk), .resetG(resetG), .req(req), .ack(ack), .result(result),
    .result_id(result_id), .result_valid(result_valid), .result_err(result_err),
    .busy(busy), .fault(fault), .measure(measure), .done(done), .datao(datao)
  );
  always #5 clk = ~clk;
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic int rr(input int last, input logic [3:0] r);
    int k;
    for (int i = 1; i <= 4; i++) begin
      k = (last + i) % 4;
      if (((r >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction
  task automatic run_txn(input int mode, input int dly, input logic [15:0] dv, input logic [3:0] keep);
    int k, id, n;
    logic [15:0] d;
    k = 0;
    while (!measure && k < 50) begin
      tick();
      k++;
    end
    if (!measure) begin
      check("start", 0, 1);
      return;
    end
    id = rr(lg, req);
    lg = id;
    check("busy_start", 32'(busy), 1);
    check("fault", 32'(fault), 32'(exp_fault));
    n = 1;
    while (n < 100) begin
      tick();
      if (!measure) break;
      n++;
    end
    check("meas_len", n, H);
    if (mode == TMO) begin
      k = 0;
      while (!result_valid && k < T + 5) begin
        tick();
        k++;
      end
      check("to_lat", 32'(k >= T && k <= T + 2), 1);
      d = '0;
    end else begin
      repeat (dly) tick();
      d = dv;
      datao = dv;
      done = 1'b1;
      tick();
    end
    check("valid", 32'(result_valid), 1);
    check("ack", 32'(ack), 32'(4'b0001 << id));
    check("id", 32'(result_id), id);
    check("result", 32'(result), 32'(d));
    check("err", 32'(result_err), 32'(mode == TMO));
    check("busy_ack", 32'(busy), 1);
    req[id] = keep[id];
    tick();
    check("pulse", 32'(result_valid), 0);
    if (mode == STUCK) begin
      k = 1;
      while (!fault && k < T + 5) begin
        tick();
        k++;
      end
      check("fault_lat", 32'(k >= T && k <= T + 2), 1);
      check("fault_set", 32'(fault), 1);
      check("busy_fault", 32'(busy), 0);
      exp_fault = 1'b1;
    end else begin
      repeat ($urandom_range(0, 3)) tick();
    end
    done = 1'b0;
  endtask
  initial begin
    int k;
    n_chk = 0;
    n_err = 0;
    req = '0;
    done = 1'b0;
    datao = '0;
    resetG = 1'b1;
    exp_fault = 1'b0;
    lg = 3;
    tick();
    tick();
    check("rst_measure", 32'(measure), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_result", 32'(result), 0);
    check("rst_id", 32'(result_id), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_err", 32'(result_err), 0);
    resetG = 1'b0;
    req = 4'b0001;
    run_txn(NORM, 100, 16'h1A2B, 4'b0000);
    req = 4'b1111;
    repeat (4) run_txn(NORM, $urandom_range(0, 10), 16'($urandom), 4'b0000);
    req = 4'b1010;
    repeat (2) run_txn(NORM, $urandom_range(0, 10), 16'($urandom), 4'b0000);
    req = 4'b0101;
    repeat (4) run_txn(NORM, $urandom_range(0, 10), 16'($urandom), 4'b0101);
    req = 4'b0100;
    run_txn(TMO, 0, 16'h0000, 4'b0000);
    req = 4'b0010;
    run_txn(NORM, 5, 16'($urandom), 4'b0000);
    repeat (30) begin
      req = req | 4'($urandom);
      if (req == 4'b0000) req = 4'b1000;
      run_txn(NORM, $urandom_range(0, 30), 16'($urandom), 4'($urandom));
    end
    req = req | 4'b0001;
    run_txn(STUCK, 3, 16'hBEEF, 4'b0000);
    req = req | 4'b0010;
    run_txn(NORM, 2, 16'($urandom), 4'b0000);
    req = 4'b0001;
    k = 0;
    while (!measure && k < 50) begin
      tick();
      k++;
    end
    check("rst_test_start", 32'(measure), 1);
    lg = rr(lg, req);
    k = 0;
    while (measure && k < 50) begin
      tick();
      k++;
    end
    repeat (5) tick();
    resetG = 1'b1;
    req = 4'b0011;
    tick();
    check("midrst_measure", 32'(measure), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ack", 32'(ack), 0);
    check("midrst_valid", 32'(result_valid), 0);
    check("midrst_fault", 32'(fault), 0);
    resetG = 1'b0;
    exp_fault = 1'b0;
    lg = 3;
    repeat (2) run_txn(NORM, $urandom_range(0, 10), 16'($urandom), 4'b0000);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
